ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL provide parameter INHIBIT_CYCLES, default 5000, clock-inhibit duration in CLOCK_50 cycles (100 us).
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 750000, whole-transaction timeout measured from clock release (15 ms).
REQ-003 SHALL have port CLOCK_50, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1; reset is synchronous, active-high, on clock CLOCK_50.
REQ-005 SHALL have port cmd_valid, input, 1, command byte offered.
REQ-006 SHALL have port cmd_data, input, 8, command byte to send to device.
REQ-007 SHALL have port cmd_ready, output, 1, high only in IDLE.
REQ-008 SHALL have port ps2_clk_in, input, 1, raw PS2_CLK pin level.
REQ-009 SHALL have port ps2_dat_in, input, 1, raw PS2_DAT pin level.
REQ-010 SHALL have port ps2_clk_oe, output, 1, 1 = drive PS2_CLK low, 0 = release.
REQ-011 SHALL have port ps2_dat_oe, output, 1, 1 = drive PS2_DAT low, 0 = release.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE; tells the receiver to discard traffic.
REQ-013 SHALL have port done, output, 1, one-cycle pulse when the device acknowledges.
REQ-014 SHALL have port error, output, 1, one-cycle pulse on NACK or timeout.
REQ-015 SHALL have port err_code, output, 2, 01 = NACK, 10 = timeout; held until the next accepted command.

Function
REQ-016 SHALL pass ps2_clk_in and ps2_dat_in through 2-flop synchronizers before any use.
REQ-017 SHALL detect a device falling edge as synced clk 1 then 0 on consecutive samples after an 8-cycle stable-high filter.
REQ-018 SHALL accept a command on cmd_valid && cmd_ready, latch cmd_data, compute odd parity, and go to INHIBIT.
REQ-019 INHIBIT SHALL drive clk_oe=1, dat_oe=0 for exactly INHIBIT_CYCLES cycles, then go to RTS.
REQ-020 RTS SHALL drive clk_oe=1 and dat_oe=1 (start bit) for 1 cycle, then go to SEND with clk_oe=0 and dat_oe=1.
REQ-021 SEND SHALL update dat_oe = ~bit at each device falling edge: edges 1-8 data LSB first, edge 9 parity, edge 10 stop (dat_oe=0).
REQ-022 At falling edge 11, SEND SHALL sample synced data: 0 = ACK and go to WAIT_IDLE; 1 = NACK, error pulse with err_code=01, go to IDLE.
REQ-023 WAIT_IDLE SHALL wait until synced clk and data are both high, then pulse done and go to IDLE.
REQ-024 A counter SHALL start at clock release; on reaching TIMEOUT_CYCLES in SEND or WAIT_IDLE the block SHALL release both lines, pulse error with err_code=10, and go to IDLE.
REQ-025 SHALL ignore cmd_valid while busy; commands are neither queued nor dropped silently because cmd_ready is low.
REQ-026 SHALL never drive both done and error in the same cycle.

Reset
REQ-027 On reset the block SHALL return to IDLE from any state, including mid-frame, within one cycle.
REQ-028 Reset values SHALL be ps2_clk_oe=0, ps2_dat_oe=0, busy=0, done=0, error=0, err_code=00, cmd_ready=1, and all counters at 0.

Structure
REQ-029 The state enum (IDLE, INHIBIT, RTS, SEND, WAIT_IDLE) and err_code constants SHALL live in package CCHW.
REQ-030 The input synchronizers SHALL be two instances of the existing Synchronizer sub-module; no other sub-modules.
REQ-031 The top level SHALL tristate each pin with pin = oe ? 1'b0 : 1'bz.

Verification
REQ-032 Send 0xF4 with a device model clocking at 12 kHz and ACKing: check line bits start 0, data 0,0,1,0,1,1,1,1, parity 0, stop 1; check done pulses once and busy falls.
REQ-033 Send 0xFF with the device NACKing at edge 11: check error pulses, err_code=01, and both oe outputs are 0.
REQ-034 Send 0x00 with no device clocks: check error pulses at TIMEOUT_CYCLES after release, err_code=10.
REQ-035 Assert reset during data bit 4: check the next cycle has oe=00, busy=0, cmd_ready=1, and a new 0xF4 completes normally.
REQ-036 Hold cmd_valid while busy with changing cmd_data: check only the first byte is transmitted and clk_oe low time equals INHIBIT_CYCLES exactly.
REQ-037 Inject a 3-cycle glitch on ps2_clk_in during SEND: check no bit advance occurs.

Source files
------------

// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter.
//   - tx_state_e  : transmitter FSM states
//   - ERR_*       : err_code values reported to the host logic
//   - FILTER_LEN  : consecutive synced-high samples required before a
//                   falling edge on the device clock is believed
//   - FRAME_EDGES : device clock falling edges in one host-to-device frame
//   - timer_width : width of a down-counter that must hold max(a, b) - 1
//   - odd_parity  : parity bit that makes the 9-bit {parity, data} odd
package CCHW;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        WAIT_IDLE
    } tx_state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_NACK    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam int FILTER_LEN  = 8;
    localparam int FRAME_EDGES = 11;

    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        if (m < 2) begin
            return 1;
        end
        return $clog2(m);
    endfunction

    function automatic logic odd_parity(input logic [7:0] b);
        return ~(^b);
    endfunction

endpackage

// File: rtl/ps2_host_tx_synchronizer.sv
// Two-flop synchronizer for one asynchronous input bit.
//   CLOCK_50 : destination clock
//   reset    : synchronous, active-high; both stages load RESET_VAL
//   d        : asynchronous input
//   q        : synchronized output, two CLOCK_50 cycles of latency
// The PS/2 lines idle high, so the default reset value is 1; a released
// bus then does not look like a falling edge when reset is removed.
module Synchronizer #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | lines released, cmd_ready high, waiting for a command
//   INHIBIT   | clock held low for INHIBIT_CYCLES to abort device traffic
//   RTS       | clock still low, data pulled low (start bit), one cycle
//   SEND      | clock released; device clocks out data, parity, stop, ack
//   WAIT_IDLE | ACK seen; waiting for the device to release both lines
//
// Ports:
//   CLOCK_50, reset          : system clock, synchronous active-high reset
//   cmd_valid/cmd_data       : command byte offer, taken when cmd_ready
//   cmd_ready                : high only in IDLE
//   ps2_clk_in/ps2_dat_in    : raw pin levels (synchronized internally)
//   ps2_clk_oe/ps2_dat_oe    : 1 = pull the line low, 0 = release
//   ps2_clk/ps2_dat          : open-drain pins driven from the oe flops
//   busy                     : high outside IDLE; receiver discards traffic
//   done                     : one-cycle pulse on device ACK
//   error                    : one-cycle pulse on NACK or timeout
//   err_code                 : 01 NACK, 10 timeout; cleared on next command
module ps2_host_tx
    import CCHW::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code,
    inout  wire        ps2_clk,
    inout  wire        ps2_dat
);

    localparam int TIMER_W = timer_width(INHIBIT_CYCLES, TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] INHIBIT_LOAD = TIMER_W'(INHIBIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);

    localparam int FILT_W = $clog2(FILTER_LEN + 1);
    localparam logic [FILT_W-1:0] FILT_FULL = FILT_W'(FILTER_LEN);

    localparam logic [3:0] EDGE_LAST = 4'(FRAME_EDGES - 1);

    logic clk_s, dat_s;

    Synchronizer #(.RESET_VAL(1'b1)) u_sync_clk (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .d        (ps2_clk_in),
        .q        (clk_s)
    );

    Synchronizer #(.RESET_VAL(1'b1)) u_sync_dat (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .d        (ps2_dat_in),
        .q        (dat_s)
    );

    // Device clock edge filter: a falling edge is only believed when the
    // synced clock has been high for FILTER_LEN consecutive samples right
    // before going low, so short high glitches during a low phase cannot
    // produce an extra edge.
    logic [FILT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic              clk_fall;

    always_comb begin
        hi_cnt_d = hi_cnt_q;
        clk_fall = 1'b0;
        if (clk_s) begin
            if (hi_cnt_q != FILT_FULL) begin
                hi_cnt_d = hi_cnt_q + FILT_W'(1);
            end
        end else begin
            hi_cnt_d = '0;
            clk_fall = (hi_cnt_q == FILT_FULL);
        end
    end

    tx_state_e          state_q, state_d;
    logic [9:0]         shift_q, shift_d;
    logic [3:0]         edge_cnt_q, edge_cnt_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               clk_oe_q, clk_oe_d;
    logic               dat_oe_q, dat_oe_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [1:0]         err_code_q, err_code_d;

    // Pin drives and pulses are registered from the next state so they
    // change on the same edge as the state and never glitch.
    // shift_q holds {stop, parity, data}; each accepted edge drives bit 0
    // and shifts in a 1, so edge 10 naturally releases data for the stop bit.
    // One down-counter serves as the inhibit timer and then, reloaded at
    // clock release, as the whole-transaction timeout.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        edge_cnt_d = edge_cnt_q;
        timer_d    = timer_q;
        clk_oe_d   = clk_oe_q;
        dat_oe_d   = dat_oe_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        err_code_d = err_code_q;

        case (state_q)
            IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (cmd_valid && cmd_ready) begin
                    shift_d    = {1'b1, odd_parity(cmd_data), cmd_data};
                    edge_cnt_d = '0;
                    timer_d    = INHIBIT_LOAD;
                    err_code_d = ERR_NONE;
                    clk_oe_d   = 1'b1;
                    state_d    = INHIBIT;
                end
            end

            INHIBIT: begin
                clk_oe_d = 1'b1;
                dat_oe_d = 1'b0;
                if (timer_q == '0) begin
                    dat_oe_d = 1'b1;
                    state_d  = RTS;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end

            RTS: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b1;
                timer_d  = TIMEOUT_LOAD;
                state_d  = SEND;
            end

            SEND: begin
                if (timer_q == '0) begin
                    clk_oe_d   = 1'b0;
                    dat_oe_d   = 1'b0;
                    error_d    = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = IDLE;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                    if (clk_fall) begin
                        edge_cnt_d = edge_cnt_q + 4'd1;
                        if (edge_cnt_q == EDGE_LAST) begin
                            // Edge 11: the device's acknowledge bit.
                            dat_oe_d = 1'b0;
                            if (dat_s) begin
                                error_d    = 1'b1;
                                err_code_d = ERR_NACK;
                                state_d    = IDLE;
                            end else begin
                                state_d = WAIT_IDLE;
                            end
                        end else begin
                            dat_oe_d = ~shift_q[0];
                            shift_d  = {1'b1, shift_q[9:1]};
                        end
                    end
                end
            end

            WAIT_IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (timer_q == '0) begin
                    error_d    = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = IDLE;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                    if (clk_s && dat_s) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            edge_cnt_q <= '0;
            timer_q    <= '0;
            hi_cnt_q   <= '0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            edge_cnt_q <= edge_cnt_d;
            timer_q    <= timer_d;
            hi_cnt_q   <= hi_cnt_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign done       = done_q;
    assign error      = error_q;
    assign err_code   = err_code_q;

    assign ps2_clk = clk_oe_q ? 1'b0 : 1'bz;
    assign ps2_dat = dat_oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a PS/2 device model.
// Timing is scaled down (short inhibit, timeout and device clock period)
// so every scenario fits in a short run; the protocol rules are unchanged.
module tb_ps2_host_tx;

    localparam int INH  = 50;
    localparam int TO   = 2000;
    localparam int HALF = 40;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready, ps2_clk_oe, ps2_dat_oe, busy, done, error;
    logic [1:0] err_code;
    logic       ps2_clk_in, ps2_dat_in;
    wire        ps2_clk_pin, ps2_dat_pin;

    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;
    logic glitch_hi   = 1'b0;

    // Open-drain bus: a line is low if either side pulls it.
    assign ps2_clk_in = glitch_hi | ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, inh_cnt = 0, rts_cnt = 0;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_data   (cmd_data),
        .cmd_ready  (cmd_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .ps2_clk    (ps2_clk_pin),
        .ps2_dat    (ps2_dat_pin)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) begin
        if (done) done_cnt++;
        if (error) err_cnt++;
        if (done && error) both_cnt++;
        if (ps2_clk_oe && !ps2_dat_oe) inh_cnt++;
        if (ps2_clk_oe && ps2_dat_oe) rts_cnt++;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line levels seen by the device: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] frame_model(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i + 1] = b[i];
            ones += int'(b[i]);
        end
        f[9]  = ((ones % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic send_cmd(input logic [7:0] d);
        int t;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 5000) begin
            @(posedge CLOCK_50); #1;
            t++;
        end
        check("ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_data  = d;
        @(posedge CLOCK_50); #1;
        cmd_valid = 1'b0;
    endtask

    // Device side of one host-to-device frame. Samples the data line in the
    // middle of each high phase, optionally ACKs, optionally injects a
    // 3-cycle high glitch in the low phase after edge 4, and optionally
    // resets the DUT in the low phase after edge abort_at.
    task automatic device_frame(input bit ack, input bit glitch, input int abort_at,
                                output logic [10:0] bits, output bit ok);
        int t;
        bits = '0;
        ok   = 1'b1;
        t    = 0;
        while (!(ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) && t < 5000) begin
            @(negedge CLOCK_50);
            t++;
        end
        if (t >= 5000) begin
            ok = 1'b0;
            return;
        end
        repeat (HALF) @(negedge CLOCK_50);
        bits[0] = ps2_dat_in;
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && ack) dev_dat_low = 1'b1;
            repeat (4) @(negedge CLOCK_50);
            dev_clk_low = 1'b1;
            if (glitch && k == 4) begin
                repeat (12) @(negedge CLOCK_50);
                glitch_hi = 1'b1;
                repeat (3) @(negedge CLOCK_50);
                glitch_hi = 1'b0;
                repeat (HALF - 15) @(negedge CLOCK_50);
            end else begin
                repeat (HALF) @(negedge CLOCK_50);
            end
            if (k == abort_at) begin
                @(posedge CLOCK_50); #1;
                reset = 1'b1;
                @(posedge CLOCK_50); #1;
                reset = 1'b0;
                @(negedge CLOCK_50);
                check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
                check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_ready", 32'(cmd_ready), 32'd1);
                check("rst_err_code", 32'(err_code), 32'd0);
                dev_clk_low = 1'b0;
                dev_dat_low = 1'b0;
                return;
            end
            dev_clk_low = 1'b0;
            repeat (HALF / 2) @(negedge CLOCK_50);
            if (k <= 10) bits[k] = ps2_dat_in;
            repeat (HALF / 2 - 4) @(negedge CLOCK_50);
        end
        dev_dat_low = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  data;
        bit          ack;
        bit          glitch;
        logic [10:0] exp_bits;
        bit          exp_done;
        bit          exp_err;
        logic [1:0]  exp_code;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [10:0] bits;
        bit          ok;
        int          d0, e0, i0, r0, t;

        vecs[0].data = 8'hF4; vecs[0].ack = 1'b1; vecs[0].glitch = 1'b0;
        vecs[1].data = 8'hFF; vecs[1].ack = 1'b0; vecs[1].glitch = 1'b0;
        vecs[2].data = 8'h00; vecs[2].ack = 1'b1; vecs[2].glitch = 1'b0;
        vecs[3].data = 8'hA5; vecs[3].ack = 1'b1; vecs[3].glitch = 1'b1;
        vecs[4].data = 8'h3C; vecs[4].ack = 1'b0; vecs[4].glitch = 1'b1;
        for (int i = 5; i < 9; i++) begin
            vecs[i].data   = 8'($urandom);
            vecs[i].ack    = 1'($urandom);
            vecs[i].glitch = 1'($urandom);
        end
        for (int i = 0; i < 9; i++) begin
            vecs[i].exp_bits = frame_model(vecs[i].data);
            vecs[i].exp_done = vecs[i].ack;
            vecs[i].exp_err  = !vecs[i].ack;
            vecs[i].exp_code = vecs[i].ack ? 2'b00 : 2'b01;
        end

        // Reset state.
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("reset_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_error", 32'(error), 32'd0);
        check("reset_err_code", 32'(err_code), 32'd0);
        check("reset_ready", 32'(cmd_ready), 32'd1);
        @(posedge CLOCK_50); #1;
        reset = 1'b0;
        repeat (20) @(posedge CLOCK_50);

        // Table-driven frames: ACK/NACK, glitches, random bytes.
        for (int i = 0; i < 9; i++) begin
            d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt; r0 = rts_cnt;
            send_cmd(vecs[i].data);
            device_frame(vecs[i].ack, vecs[i].glitch, 0, bits, ok);
            check("frame_started", 32'(ok), 32'd1);
            check($sformatf("bits_%0d_%02h", i, vecs[i].data), 32'(bits), 32'(vecs[i].exp_bits));
            repeat (20) @(negedge CLOCK_50);
            check("inhibit_len", 32'(inh_cnt - i0), 32'(INH));
            check("rts_len", 32'(rts_cnt - r0), 32'd1);
            check("done_pulses", 32'(done_cnt - d0), 32'(vecs[i].exp_done));
            check("error_pulses", 32'(err_cnt - e0), 32'(vecs[i].exp_err));
            check("err_code", 32'(err_code), 32'(vecs[i].exp_code));
            check("end_busy", 32'(busy), 32'd0);
            check("end_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
        end

        // Timeout: 0x00 with no device clocks.
        d0 = done_cnt; e0 = err_cnt;
        send_cmd(8'h00);
        t = 0;
        while (!(ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) && t < 5000) begin
            @(negedge CLOCK_50);
            t++;
        end
        check("to_release_seen", 32'(t < 5000), 32'd1);
        t = 0;
        while (error !== 1'b1 && t < 3 * TO) begin
            @(negedge CLOCK_50);
            t++;
        end
        check("to_latency", 32'(t), 32'(TO));
        check("to_err_code", 32'(err_code), 32'd2);
        check("to_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
        repeat (5) @(negedge CLOCK_50);
        check("to_error_pulses", 32'(err_cnt - e0), 32'd1);
        check("to_done_pulses", 32'(done_cnt - d0), 32'd0);
        check("to_busy", 32'(busy), 32'd0);

        // Reset during data bit 4, then a clean 0xF4.
        send_cmd(8'hF4);
        device_frame(1'b1, 1'b0, 4, bits, ok);
        check("abort_started", 32'(ok), 32'd1);
        repeat (30) @(negedge CLOCK_50);
        d0 = done_cnt; e0 = err_cnt;
        send_cmd(8'hF4);
        device_frame(1'b1, 1'b0, 0, bits, ok);
        repeat (20) @(negedge CLOCK_50);
        check("post_rst_bits", 32'(bits), 32'(frame_model(8'hF4)));
        check("post_rst_done", 32'(done_cnt - d0), 32'd1);
        check("post_rst_error", 32'(err_cnt - e0), 32'd0);

        // cmd_valid held through a whole transaction with changing data.
        d0 = done_cnt; i0 = inh_cnt; r0 = rts_cnt;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 5000) begin
            @(posedge CLOCK_50); #1;
            t++;
        end
        cmd_valid = 1'b1;
        cmd_data  = 8'h3C;
        @(posedge CLOCK_50); #1;
        fork
            device_frame(1'b1, 1'b0, 0, bits, ok);
            begin
                repeat (300) begin
                    cmd_data = 8'($urandom);
                    @(posedge CLOCK_50); #1;
                end
                cmd_valid = 1'b0;
            end
        join
        repeat (100) @(negedge CLOCK_50);
        check("hold_bits", 32'(bits), 32'(frame_model(8'h3C)));
        check("hold_inhibit_len", 32'(inh_cnt - i0), 32'(INH));
        check("hold_rts_len", 32'(rts_cnt - r0), 32'd1);
        check("hold_done", 32'(done_cnt - d0), 32'd1);
        check("hold_busy", 32'(busy), 32'd0);

        check("done_error_overlap", 32'(both_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
